// File: rtl/msrv_32_pkg.sv
// msrv_32_pkg: shared types and constants for the msrv_32 front end.
//   XLEN          - architectural register/address width
//   NOP_INSTR     - addi x0,x0,0; what the instruction mux injects on a bubble
//   fetch_state_e - fetch controller state (IDLE / WAIT / DROP)
//   fetch_entry_t - one buffered fetch: PC plus instruction word
package msrv_32_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // IDLE: nothing pending. WAIT: pending, data kept. DROP: pending, data thrown away.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/msrv_32_instr_fetch_unit_if.sv
// msrv_32_instr_fetch_unit_if: instruction memory read bus.
//   imem_req_out   - one-cycle read strobe (fetch unit -> memory)
//   imem_addr_out  - word address, valid with imem_req_out
//   imem_rvalid_in - read data valid, in-order responses (memory -> fetch unit)
//   imem_rdata_in  - instruction word
// master: fetch unit side; slave: memory side.
interface msrv_32_instr_fetch_unit_if;
  import msrv_32_pkg::*;

  logic            imem_req_out;
  logic [XLEN-1:0] imem_addr_out;
  logic            imem_rvalid_in;
  logic [XLEN-1:0] imem_rdata_in;

  modport master (
    output imem_req_out, imem_addr_out,
    input  imem_rvalid_in, imem_rdata_in
  );

  modport slave (
    input  imem_req_out, imem_addr_out,
    output imem_rvalid_in, imem_rdata_in
  );

endinterface

// File: rtl/msrv_32_fetch_buffer.sv
// msrv_32_fetch_buffer: BUF_DEPTH-entry synchronous FIFO of {pc, instr}.
//   clk, rst   - clock, synchronous active-high reset
//   push/data  - enqueue push_data
//   pop        - dequeue head (ignored when empty)
//   clear      - drop all entries; wins over push and pop
//   head       - current head entry (undefined when empty)
//   count      - occupancy; empty / full flags
// BUF_DEPTH must be a power of two (2 or 4) so the pointers wrap naturally.
module msrv_32_fetch_buffer
  import msrv_32_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  fetch_entry_t               push_data,
  output fetch_entry_t               head,
  output logic [$clog2(BUF_DEPTH):0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  mem [BUF_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(BUF_DEPTH));
  assign do_pop  = pop && !empty;
  // Push on full is accepted only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clear && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/msrv_32_instr_fetch_unit.sv
// msrv_32_instr_fetch_unit: msrv_32 front end.
// Issues single-outstanding word reads, buffers returned words with their PCs,
// and presents the buffer head downstream. Redirects squash buffered and
// in-flight fetches.
//   ms_riscv32_mp_clk_in - core clock
//   ms_riscv32_mp_rst_in - synchronous active-high reset
//   imem                 - instruction memory bus (master modport)
//   redirect_in/_pc_in   - branch/jump/trap redirect strobe and target
//   stall_in             - downstream not ready; hold head
//   instr_valid_out      - instr_out/pc_out carry a real instruction
//   instr_out, pc_out    - head instruction and its PC (NOP / last PC when empty)
//   flush_out            - bubble request to the instruction mux (~instr_valid_out)
module msrv_32_instr_fetch_unit
  import msrv_32_pkg::*;
#(
  parameter logic [XLEN-1:0] BOOT_ADDR = 32'h0000_0000,
  parameter int              BUF_DEPTH = 2
) (
  input  logic                              ms_riscv32_mp_clk_in,
  input  logic                              ms_riscv32_mp_rst_in,
  msrv_32_instr_fetch_unit_if.master        imem,
  input  logic                              redirect_in,
  input  logic [XLEN-1:0]                   redirect_pc_in,
  input  logic                              stall_in,
  output logic                              instr_valid_out,
  output logic [XLEN-1:0]                   instr_out,
  output logic [XLEN-1:0]                   pc_out,
  output logic                              flush_out
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic            clk, rst;
  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] fetch_pc, req_pc, last_pc;
  logic [CW-1:0]   count, count_after_pop;
  logic            empty, full, push, pop, issue;
  fetch_entry_t    head, push_data;

  assign clk = ms_riscv32_mp_clk_in;
  assign rst = ms_riscv32_mp_rst_in;

  assign pop             = !empty && !stall_in && !redirect_in;
  assign count_after_pop = count - CW'(pop);
  assign push            = imem.imem_rvalid_in && (state == WAIT) && !redirect_in && !rst;
  assign push_data       = '{pc: req_pc, instr: imem.imem_rdata_in};

  // State register. Reset does not forget a pending read: it turns it into
  // DROP so the stale response cannot be mistaken for a post-reset fetch.
  always_ff @(posedge clk) begin
    if (rst) state <= (state != IDLE && !imem.imem_rvalid_in) ? DROP : IDLE;
    else     state <= state_nxt;
  end

  // Next state. A redirect in the response cycle consumes the response,
  // so the read is finished rather than left to drop.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (issue) state_nxt = WAIT;
      WAIT: begin
        if (redirect_in)               state_nxt = imem.imem_rvalid_in ? IDLE : DROP;
        else if (imem.imem_rvalid_in)  state_nxt = IDLE;
      end
      DROP: if (imem.imem_rvalid_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs. Issue reserves a buffer slot for the response, so a push can
  // never land on a full buffer.
  always_comb begin
    issue = 1'b0;
    if (state == IDLE && !redirect_in && !rst && count_after_pop < CW'(BUF_DEPTH))
      issue = 1'b1;
  end

  assign imem.imem_req_out  = issue;
  assign imem.imem_addr_out = fetch_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= BOOT_ADDR;
      req_pc   <= BOOT_ADDR;
      last_pc  <= BOOT_ADDR;
    end else begin
      if (redirect_in) begin
        fetch_pc <= word_align(redirect_pc_in);
      end else if (issue) begin
        fetch_pc <= fetch_pc + 32'd4;
        req_pc   <= fetch_pc;
      end
      if (pop) last_pc <= head.pc;
    end
  end

  msrv_32_fetch_buffer #(.BUF_DEPTH(BUF_DEPTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .clear     (redirect_in),
    .push_data (push_data),
    .head      (head),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  assign instr_valid_out = !empty;
  assign flush_out       = empty;
  assign instr_out       = empty ? NOP_INSTR : head.instr;
  assign pc_out          = empty ? last_pc : head.pc;

  a_no_push_on_full: assert property (@(posedge clk) disable iff (rst || redirect_in)
    !(push && full && !pop));

endmodule
